// File: rtl/sync_w2r_mon_if.sv
// sync_w2r_mon_if
//   Bundles the read-side signals of the write-to-read pointer synchroniser.
//   slave  : view taken by sync_w2r_mon (pointer inputs in, status out)
//   master : view taken by the read-domain logic that drives and observes it
//   wptr        Gray write pointer from the wclk domain (asynchronous to rclk)
//   rptr_bin    binary read pointer, rclk domain
//   ae_thresh   almost-empty threshold, quasi-static
//   err_clr     single-cycle pulse clearing both sticky errors
//   rq_wptr     synchronised Gray write pointer
//   rq_wptr_bin binary form of rq_wptr
//   rd_count    registered occupancy
//   rd_empty    registered empty flag
//   rd_aempty   registered almost-empty flag
//   sync_valid  chain flushed since reset
//   gray_err    sticky Gray-step violation
//   ovf_err     sticky impossible-occupancy flag
interface sync_w2r_mon_if #(
   parameter int unsigned ADDRSIZE = 4
);
   logic [ADDRSIZE:0] wptr;
   logic [ADDRSIZE:0] rptr_bin;
   logic [ADDRSIZE:0] ae_thresh;
   logic              err_clr;
   logic [ADDRSIZE:0] rq_wptr;
   logic [ADDRSIZE:0] rq_wptr_bin;
   logic [ADDRSIZE:0] rd_count;
   logic              rd_empty;
   logic              rd_aempty;
   logic              sync_valid;
   logic              gray_err;
   logic              ovf_err;

   modport slave (
      input  wptr, rptr_bin, ae_thresh, err_clr,
      output rq_wptr, rq_wptr_bin, rd_count, rd_empty, rd_aempty,
             sync_valid, gray_err, ovf_err
   );

   modport master (
      output wptr, rptr_bin, ae_thresh, err_clr,
      input  rq_wptr, rq_wptr_bin, rd_count, rd_empty, rd_aempty,
             sync_valid, gray_err, ovf_err
   );
endinterface

// File: rtl/sync_w2r_mon.sv
// sync_w2r_mon
//   Carries the Gray write pointer into the rclk domain through a
//   SYNC_STAGES-deep flop chain, converts it to binary, and derives the
//   registered read-side occupancy, empty and almost-empty flags. Every
//   synchronised sample is checked for multi-bit Gray steps and for an
//   occupancy above 2^ADDRSIZE; both are reported as sticky errors.
//   Ports:
//     rclk    read-domain clock
//     rrst_n  asynchronous active-low reset
//     bus     sync_w2r_mon_if.slave (pointers, threshold, status, errors)
//   Parameters:
//     ADDRSIZE     FIFO address width (pointers are ADDRSIZE+1 bits)
//     SYNC_STAGES  synchroniser depth, 2..4
module sync_w2r_mon #(
   parameter int unsigned ADDRSIZE    = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          rclk,
   input  logic          rrst_n,
   sync_w2r_mon_if.slave bus
);
   localparam int unsigned   PW       = ADDRSIZE + 1;
   localparam int unsigned   VMAX     = SYNC_STAGES + 1;
   localparam int unsigned   CW       = $clog2(VMAX + 1);
   localparam logic [CW-1:0] VMAX_C   = CW'(VMAX);
   localparam logic [PW-1:0] FULL_LVL = {1'b1, {ADDRSIZE{1'b0}}};

   logic [SYNC_STAGES-1:0][PW-1:0] stage;
   logic [PW-1:0]                  prev_g;
   logic [PW-1:0]                  wbin;
   logic [PW-1:0]                  occ;
   logic [PW-1:0]                  gdiff;
   logic [CW-1:0]                  vcnt;
   logic                           gray_viol;
   logic                           ovf_viol;

   // Plain flop chain: nothing may sit between stages.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         stage <= '0;
      end else begin
         stage <= {stage[SYNC_STAGES-2:0], bus.wptr};
      end
   end

   assign bus.rq_wptr = stage[SYNC_STAGES-1];

   // Binary bit i is the XOR of all Gray bits from i upwards.
   always_comb begin
      wbin = '0;
      for (int unsigned i = 0; i < PW; i++) begin
         wbin[i] = ^(bus.rq_wptr >> i);
      end
   end

   assign bus.rq_wptr_bin = wbin;
   assign occ             = wbin - bus.rptr_bin;
   assign bus.sync_valid  = (vcnt == VMAX_C);

   // More than one bit set in the sample-to-sample difference: x & (x-1) is
   // nonzero exactly when x has two or more ones.
   assign gdiff     = bus.rq_wptr ^ prev_g;
   assign gray_viol = bus.sync_valid && ((gdiff & (gdiff - PW'(1))) != '0);
   assign ovf_viol  = bus.sync_valid && (occ > FULL_LVL);

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         prev_g        <= '0;
         vcnt          <= '0;
         bus.rd_count  <= '0;
         bus.rd_empty  <= 1'b1;
         bus.rd_aempty <= 1'b1;
         bus.gray_err  <= 1'b0;
         bus.ovf_err   <= 1'b0;
      end else begin
         prev_g <= bus.rq_wptr;
         if (vcnt != VMAX_C) begin
            vcnt <= vcnt + CW'(1);
         end
         bus.rd_count  <= occ;
         bus.rd_empty  <= (occ == '0);
         bus.rd_aempty <= (occ <= bus.ae_thresh);
         // A new violation outranks a coincident clear.
         bus.gray_err  <= (bus.gray_err & ~bus.err_clr) | gray_viol;
         bus.ovf_err   <= (bus.ovf_err & ~bus.err_clr) | ovf_viol;
      end
   end
endmodule
